// File: rtl/inst_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_ctrl_pkg
// Shared types and parameters for the instruction-memory boot controller.
//   addr_t        : byte address on the instruction memory port
//   inst_t        : one 32-bit instruction word
//   ldr_state_t   : boot loader FSM states
//   InstStartFrom : byte address of the first instruction word
//   InstSpace     : instruction region size in bytes
//   MaxWords      : number of words that fit in the region
//   len_ok()      : true when a requested load length fits the region
// ---------------------------------------------------------------------------
package inst_mem_ctrl_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  // Explicit encodings keep the state values stable for legacy tooling.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } ldr_state_t;

  localparam addr_t       InstStartFrom = 32'h0000_0100;
  localparam int unsigned InstSpace     = 64;
  localparam int unsigned MaxWords      = InstSpace >> 2;

  // A zero-length load or one that would run past the region is rejected.
  function automatic logic len_ok(input logic [15:0] len);
    return (len != 16'd0) && (32'(len) <= MaxWords);
  endfunction

endpackage

// File: rtl/inst_mem_ctrl_byte_packer.sv
// ---------------------------------------------------------------------------
// inst_mem_ctrl_byte_packer
// Assembles four bytes into a little-endian 32-bit word.
//   clk          : clock
//   rst          : synchronous active-low reset
//   i_clr        : restart assembly at byte 0 and clear the word
//   i_accept     : a byte is accepted this cycle
//   i_data       : byte value
//   o_word       : assembled word register
//   o_word_done  : the byte accepted this cycle completes the word
// ---------------------------------------------------------------------------
module inst_mem_ctrl_byte_packer
  import inst_mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_accept,
  input  logic [7:0] i_data,
  output inst_t      o_word,
  output logic       o_word_done
);

  logic [1:0] r_idx;
  inst_t      r_word;
  logic [3:0] w_lane_we;

  // One write enable per byte lane, selected by the running byte index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_we[gi] = i_accept & (r_idx == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else begin
      if (i_accept) begin
        r_idx <= r_idx + 2'd1;
      end
      for (int li = 0; li < 4; li++) begin
        if (w_lane_we[li]) begin
          r_word[8*li +: 8] <= i_data;
        end
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_done = w_lane_we[3];

endmodule

// File: rtl/inst_mem_ctrl.sv
// ---------------------------------------------------------------------------
// inst_mem_ctrl
// Boot-time loader and port arbiter for the instruction memory. Receives a
// byte stream, packs little-endian words, writes them from InstStartFrom
// upward, then releases the core and hands the memory port to fetch.
//   clk, rst              : clock, synchronous active-low reset
//   boot_req, load_len    : start a load of load_len words
//   byte_valid/data/ready : programming byte handshake
//   fetch_req, fetch_addr : core instruction fetch
//   mem_cs/we/addr/wdata  : instruction memory single port
//   core_stall            : core must hold its PC
//   busy, done, err       : session in progress / completion pulse / reject
// ---------------------------------------------------------------------------
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_req,
  input  logic [15:0] load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        fetch_req,
  input  addr_t       fetch_addr,
  output logic        mem_cs,
  output logic        mem_we,
  output addr_t       mem_addr,
  output inst_t       mem_wdata,
  output logic        core_stall,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ldr_state_t  r_state;
  ldr_state_t  w_state_next;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic        r_done;

  logic        w_len_ok;
  logic        w_boot_idle;
  logic        w_start;
  logic        w_accept;
  logic        w_word_done;
  inst_t       w_word;
  logic [15:0] w_cnt_inc;

  assign w_len_ok    = len_ok(load_len);
  // boot_req is only honoured where no session is in flight.
  assign w_boot_idle = (r_state == IDLE) || (r_state == RUN) || (r_state == ERR);
  assign w_start     = w_boot_idle & boot_req & w_len_ok;
  assign w_accept    = byte_valid & (r_state == RECV);
  assign w_cnt_inc   = r_word_cnt + 16'd1;

  inst_mem_ctrl_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_start),
    .i_accept    (w_accept),
    .i_data      (byte_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, RUN, ERR: begin
        if (boot_req) begin
          w_state_next = w_len_ok ? RECV : ERR;
        end
      end
      RECV: begin
        if (w_word_done) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_state_next = (w_cnt_inc == r_len) ? RUN : RECV;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_len      <= load_len;
        r_word_cnt <= 16'd0;
      end else if (r_state == WRITE) begin
        r_word_cnt <= w_cnt_inc;
      end
      // done is high only on the first RUN cycle following the last write.
      r_done <= (r_state == WRITE) && (w_state_next == RUN);
    end
  end

  // Port ownership and status are decoded from the registered state; the
  // only input-driven outputs are the fetch pass-through signals in RUN.
  always_comb begin
    byte_ready = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_stall = 1'b1;
    busy       = 1'b0;
    err        = 1'b0;
    case (r_state)
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = InstStartFrom + 32'({r_word_cnt, 2'b00});
        mem_wdata = w_word;
        busy      = 1'b1;
      end
      RUN: begin
        core_stall = 1'b0;
        mem_cs     = fetch_req;
        mem_addr   = fetch_addr;
      end
      ERR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

  assign done = r_done;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
module tb_inst_mem_ctrl;
  import inst_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        boot_req = 1'b0;
  logic [15:0] load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        fetch_req = 1'b0;
  addr_t       fetch_addr = '0;
  logic        mem_cs;
  logic        mem_we;
  addr_t       mem_addr;
  inst_t       mem_wdata;
  logic        core_stall;
  logic        busy;
  logic        done;
  logic        err;

  inst_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .boot_req   (boot_req),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_stall (core_stall),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    addr_t a;
    inst_t d;
  } wr_t;

  wr_t   exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_writes = 0;
  addr_t last_wr_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every memory write is popped against the scoreboard.
  always @(negedge clk) begin
    if (mem_cs === 1'b1 && mem_we === 1'b1) begin
      wr_t e;
      n_writes++;
      last_wr_addr = mem_addr;
      $display("WR  addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot(input logic [15:0] len);
    boot_req = 1'b1;
    load_len = len;
    tick();
    boot_req = 1'b0;
  endtask

  task automatic push_word(input int idx, input inst_t d);
    wr_t e;
    e.a = InstStartFrom + 32'(idx * 4);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Sends one word LSB first; gap idle cycles follow each byte except the
  // final byte of the session.
  task automatic send_word(input inst_t w, input int gap, input bit last);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap > 0 && !(last && k == 3)) begin
        byte_valid = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          if (k != 3) check("ready_in_gap", byte_ready, 32'd1);
          @(posedge clk);
          #1;
        end
      end
    end
    if (last) byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int t;
    at = -1;
    t  = 0;
    while (t < 300 && at < 0) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        check("stall_at_done", core_stall, 32'd0);
      end
      t++;
    end
    if (at < 0) check("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int    k0;
    int    done_at;
    int    wr_before;
    inst_t w;

    // Reset with random inputs.
    boot_req   = 1'($urandom);
    load_len   = 16'($urandom);
    byte_valid = 1'($urandom);
    byte_data  = 8'($urandom);
    fetch_req  = 1'b1;
    fetch_addr = $urandom;
    tick();
    boot_req   = 1'($urandom);
    load_len   = 16'($urandom_range(1, 4));
    byte_valid = 1'($urandom);
    fetch_addr = $urandom;
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 32'd0);
    check("rst_mem_cs", mem_cs, 32'd0);
    check("rst_mem_we", mem_we, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_stall", core_stall, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_err", err, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    boot_req = 1'b0;
    byte_valid = 1'b0;
    fetch_req = 1'b0;

    // Two-word load with continuous valid.
    push_word(0, 32'h1234_5678);
    push_word(1, 32'hDEAD_BEEF);
    k0 = cyc;
    boot(16'd2);
    send_word(32'h1234_5678, 0, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 1'b1);
    wait_done(done_at);
    check("done_cycle", 32'(done_at), 32'(k0 + 11));
    fetch_req  = 1'b1;
    fetch_addr = InstStartFrom + 32'd4;
    @(negedge clk);
    check("fetch_cs", mem_cs, 32'd1);
    check("fetch_we", mem_we, 32'd0);
    check("fetch_addr", mem_addr, InstStartFrom + 32'd4);
    check("done_one_cycle", done, 32'd0);
    tick();
    fetch_req = 1'b0;

    // Gapped valid, reloaded from RUN.
    push_word(0, 32'h1234_5678);
    push_word(1, 32'hDEAD_BEEF);
    boot(16'd2);
    @(negedge clk);
    check("gap_busy", busy, 32'd1);
    @(posedge clk);
    #1;
    send_word(32'h1234_5678, 3, 1'b0);
    send_word(32'hDEAD_BEEF, 3, 1'b1);
    wait_done(done_at);

    // Invalid lengths.
    wr_before = n_writes;
    boot(16'd0);
    @(negedge clk);
    check("err_len0", err, 32'd1);
    check("err_stall", core_stall, 32'd1);
    @(posedge clk);
    #1;
    boot(16'(MaxWords + 1));
    @(negedge clk);
    check("err_len_max1", err, 32'd1);
    check("err_no_ready", byte_ready, 32'd0);
    @(posedge clk);
    #1;
    check("err_no_write", 32'(n_writes), 32'(wr_before));
    push_word(0, 32'hCAFE_F00D);
    boot(16'd1);
    @(negedge clk);
    check("err_cleared", err, 32'd0);
    check("err_to_recv", byte_ready, 32'd1);
    @(posedge clk);
    #1;
    send_word(32'hCAFE_F00D, 0, 1'b1);
    wait_done(done_at);

    // Reset after six bytes of a four-word load.
    wr_before = n_writes;
    push_word(0, 32'h0403_0201);
    boot(16'd4);
    send_word(32'h0403_0201, 0, 1'b0);
    send_byte(8'h05);
    send_byte(8'h06);
    byte_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_stall", core_stall, 32'd1);
      check("midrst_ready", byte_ready, 32'd0);
      check("midrst_busy", busy, 32'd0);
      @(posedge clk);
      #1;
    end
    check("midrst_writes", 32'(n_writes), 32'(wr_before + 1));
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reload from RUN with a coincident fetch.
    push_word(0, 32'h89AB_CDEF);
    boot(16'd1);
    send_word(32'h89AB_CDEF, 0, 1'b1);
    wait_done(done_at);
    push_word(0, 32'h7654_3210);
    fetch_req  = 1'b1;
    fetch_addr = InstStartFrom + 32'd8;
    boot_req   = 1'b1;
    load_len   = 16'd1;
    @(negedge clk);
    check("reload_fetch_cs", mem_cs, 32'd1);
    check("reload_fetch_we", mem_we, 32'd0);
    check("reload_fetch_addr", mem_addr, InstStartFrom + 32'd8);
    check("reload_no_stall", core_stall, 32'd0);
    @(posedge clk);
    #1;
    boot_req = 1'b0;
    @(negedge clk);
    check("reload_stall", core_stall, 32'd1);
    check("reload_cs_off", mem_cs, 32'd0);
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    send_word(32'h7654_3210, 0, 1'b1);
    wait_done(done_at);

    // Full region load.
    boot(16'(MaxWords));
    for (int i = 0; i < int'(MaxWords); i++) begin
      w = $urandom;
      push_word(i, w);
      send_word(w, 0, (i == int'(MaxWords) - 1));
    end
    wait_done(done_at);
    check("max_last_addr", last_wr_addr, InstStartFrom + 32'(InstSpace) - 32'd4);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
